sha256_kw_sequencer: RTL

- Round-stream producer for the SHA-256 compression core; it sits on the address side of the K-constant ROM.
- Accepts one 512-bit padded message block and steps round index t through 0..63, driving that index as the ROM address.
- Expands the message schedule W_t in a 16-word sliding window.
- Emits K_t+W_t (mod 2^32) per round to the compression datapath over a valid/ready handshake.

---
 rtl/sha256_kw_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/sha256_kw_sequencer.sv
// SHA-256 round-stream producer: steps t through 0..ROUNDS-1, addresses the K ROM and
// emits K_t+W_t. Optional `SHA256_KW_ABORT_EN adds an abort input that drops the current block.
module sha256_kw_sequencer #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SHA256_KW_ABORT_EN
    input  logic         abort,
`endif
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic [5:0]   k_addr,
    input  logic [31:0]  k_data,
    output logic         kw_valid,
    input  logic         kw_ready,
    output logic [31:0]  kw_data,
    output logic [5:0]   kw_round,
    output logic         kw_last,
    output logic         busy
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic        run;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    state_d = RUN;
                    t_d     = '0;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk_data[511 - 32*i -: 32];
                    end
                end
            end
            RUN: begin
                if (kw_ready) begin
                    if (t_q == LAST_T) begin
                        state_d = IDLE;
                        t_d     = '0;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            w_d[i] = w_q[i+1];
                        end
                        w_d[15] = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
                        t_d     = t_q + 6'd1;
                    end
                end
`ifdef SHA256_KW_ABORT_EN
                // Abort wins over a same-cycle transfer; the window is left as-is (don't-care).
                if (abort) begin
                    state_d = IDLE;
                    t_d     = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
        end
    end

    // Outputs come only from registered state plus the ROM data for the current address.
    assign run       = (state_q == RUN);
    assign blk_ready = !run;
    assign busy      = run;
    assign kw_valid  = run;
    assign k_addr    = t_q;
    assign kw_round  = t_q;
    assign kw_last   = run && (t_q == LAST_T);
    assign kw_data   = run ? (k_data + w_q[0]) : 32'h0;

endmodule
